// File: rtl/hall_pkg.sv
// Shared hall-sensor definitions: sector codes, the hall-code-to-sector
// mapping and adjacency helpers. The commutation stage imports the same
// mapping, so both blocks agree on what each sector means.
package hall_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 64;

  localparam logic [2:0] SECTOR_INVALID = 3'd0;
  localparam logic [2:0] SECTOR_1       = 3'd1;
  localparam logic [2:0] SECTOR_2       = 3'd2;
  localparam logic [2:0] SECTOR_3       = 3'd3;
  localparam logic [2:0] SECTOR_4       = 3'd4;
  localparam logic [2:0] SECTOR_5       = 3'd5;
  localparam logic [2:0] SECTOR_6       = 3'd6;

  // code = {hall_1, hall_2, hall_3}
  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    logic [2:0] s;
    case (code)
      3'b100:  s = SECTOR_1;
      3'b110:  s = SECTOR_2;
      3'b010:  s = SECTOR_3;
      3'b011:  s = SECTOR_4;
      3'b001:  s = SECTOR_5;
      3'b101:  s = SECTOR_6;
      default: s = SECTOR_INVALID;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] sector_next(input logic [2:0] s);
    return (s == SECTOR_6) ? SECTOR_1 : s + 3'd1;
  endfunction

  function automatic logic [2:0] sector_prev(input logic [2:0] s);
    return (s == SECTOR_1) ? SECTOR_6 : s - 3'd1;
  endfunction

endpackage

// File: rtl/hall_conditioner_debounce.sv
// Single hall channel: 2-FF synchroniser followed by a persistence filter.
// The filtered bit only follows the synchronised bit after it has disagreed
// for DEBOUNCE_CYCLES consecutive cycles.
//   clk, rst  : clock, synchronous active-high reset
//   raw       : asynchronous sensor pin
//   filtered  : synchronised, debounced level
module hall_debounce #(
  parameter int DEBOUNCE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filtered
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      filtered <= 1'b0;
      count    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // any agreement restarts the persistence window
      if (sync2 == filtered) begin
        count <= '0;
      end else if (count == LAST) begin
        filtered <= sync2;
        count    <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hall_conditioner.sv
// Hall sensor conditioner for the linear BLDC motor: debounces the three
// hall pins, decodes the sector, tracks signed step position and direction,
// and measures the step period for the speed/current loops.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : counting/measurement enable
//   hall_raw_1..3       : asynchronous hall pins
//   hall_1..3           : debounced hall bits (to commutation)
//   sector, hall_valid  : registered decode, 0 / low on 000 or 111
//   step_strobe, direction, position : legal adjacent step tracking
//   period, period_valid, stall      : step period measurement
//   skip_error, invalid_error        : non-adjacent jump pulse, bad code level
module hall_conditioner
  import hall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int POS_WIDTH       = 32,
  parameter int PERIOD_WIDTH    = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        hall_raw_1,
  input  logic                        hall_raw_2,
  input  logic                        hall_raw_3,
  output logic                        hall_1,
  output logic                        hall_2,
  output logic                        hall_3,
  output logic [2:0]                  sector,
  output logic                        hall_valid,
  output logic                        step_strobe,
  output logic                        direction,
  output logic signed [POS_WIDTH-1:0] position,
  output logic [PERIOD_WIDTH-1:0]     period,
  output logic                        period_valid,
  output logic                        stall,
  output logic                        skip_error,
  output logic                        invalid_error
);

  localparam logic [PERIOD_WIDTH-1:0] PMAX = '1;

  logic [2:0] raw_bus, filt;
  logic [2:0] dec, prev_sector;
  logic       dec_valid, init, seen_strobe;
  logic       evaluate, is_fwd, is_rev, step;
  logic [PERIOD_WIDTH-1:0] count;

  assign raw_bus = {hall_raw_1, hall_raw_2, hall_raw_3};

  for (genvar i = 0; i < 3; i++) begin : g_ch
    hall_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw_bus[i]),
      .filtered (filt[i])
    );
  end

  assign hall_1 = filt[2];
  assign hall_2 = filt[1];
  assign hall_3 = filt[0];

  // decode is evaluated against the registered sector so a step is judged
  // in the same edge that publishes the new sector
  assign dec       = hall_to_sector(filt);
  assign dec_valid = (dec != SECTOR_INVALID);
  assign evaluate  = enable && init && dec_valid && (dec != sector);
  assign is_fwd    = (dec == sector_next(prev_sector));
  assign is_rev    = (dec == sector_prev(prev_sector));
  assign step      = evaluate && (is_fwd || is_rev);

  always_ff @(posedge clk) begin
    if (rst) begin
      sector        <= SECTOR_INVALID;
      hall_valid    <= 1'b0;
      invalid_error <= 1'b0;
      step_strobe   <= 1'b0;
      skip_error    <= 1'b0;
      direction     <= 1'b0;
      position      <= '0;
      prev_sector   <= SECTOR_INVALID;
      init          <= 1'b0;
      seen_strobe   <= 1'b0;
      count         <= '0;
      period        <= '0;
      period_valid  <= 1'b0;
      stall         <= 1'b0;
    end else begin
      sector        <= dec;
      hall_valid    <= dec_valid;
      invalid_error <= !dec_valid;
      step_strobe   <= 1'b0;
      skip_error    <= 1'b0;

      if (!enable) begin
        init         <= 1'b0;
        seen_strobe  <= 1'b0;
        count        <= '0;
        period_valid <= 1'b0;
        stall        <= 1'b0;
      end else begin
        // first valid code after reset/enable only seeds the tracker
        if (!init && dec_valid) begin
          init        <= 1'b1;
          prev_sector <= dec;
        end else if (evaluate) begin
          prev_sector <= dec;
          if (is_fwd) begin
            step_strobe <= 1'b1;
            direction   <= 1'b1;
            position    <= position + POS_WIDTH'(1);
          end else if (is_rev) begin
            step_strobe <= 1'b1;
            direction   <= 1'b0;
            position    <= position - POS_WIDTH'(1);
          end else begin
            skip_error  <= 1'b1;
          end
        end

        if (step) begin
          period       <= (count == PMAX) ? PMAX : count + 1'b1;
          count        <= '0;
          stall        <= 1'b0;
          // the strobe that ends a stall measures a bogus interval
          period_valid <= seen_strobe && !stall;
          seen_strobe  <= 1'b1;
        end else if (count != PMAX) begin
          count <= count + 1'b1;
          if (count == PMAX - 1'b1) begin
            stall        <= 1'b1;
            period_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hall_conditioner.sv
module tb_hall_conditioner;

  localparam int D = 4;

  logic clk = 0;
  logic rst, enable;
  logic [2:0] raw;  // {hall_raw_1, hall_raw_2, hall_raw_3}

  logic        h1, h2, h3, hv, stb, dir, pv, stl, skp, inv;
  logic [2:0]  sec;
  logic signed [31:0] pos;
  logic [23:0] per;

  logic        a1, a2, a3, ahv, astb, adir, apv, astl, askp, ainv;
  logic [2:0]  asec;
  logic signed [31:0] apos;
  logic [7:0]  aper;

  always #5 clk = ~clk;

  hall_conditioner #(.DEBOUNCE_CYCLES(D), .POS_WIDTH(32), .PERIOD_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .hall_raw_1(raw[2]), .hall_raw_2(raw[1]), .hall_raw_3(raw[0]),
    .hall_1(h1), .hall_2(h2), .hall_3(h3), .sector(sec), .hall_valid(hv),
    .step_strobe(stb), .direction(dir), .position(pos), .period(per),
    .period_valid(pv), .stall(stl), .skip_error(skp), .invalid_error(inv));

  hall_conditioner #(.DEBOUNCE_CYCLES(D), .POS_WIDTH(32), .PERIOD_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable),
    .hall_raw_1(raw[2]), .hall_raw_2(raw[1]), .hall_raw_3(raw[0]),
    .hall_1(a1), .hall_2(a2), .hall_3(a3), .sector(asec), .hall_valid(ahv),
    .step_strobe(astb), .direction(adir), .position(apos), .period(aper),
    .period_valid(apv), .stall(astl), .skip_error(askp), .invalid_error(ainv));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int code2sec(input bit [2:0] c);
    case (c)
      3'b100: return 1; 3'b110: return 2; 3'b010: return 3;
      3'b011: return 4; 3'b001: return 5; 3'b101: return 6;
      default: return 0;
    endcase
  endfunction

  // hist[ch][0..D] holds raw samples of the last D+1 edges, oldest first;
  // a filtered bit flips when the D oldest all disagree with it.
  bit     hist [3][D+1];
  bit [2:0] m_filt;
  int     m_sector, m_prev, m_pos, m_nstr;
  longint m_cyc, m_period;
  bit     m_hv, m_inv, m_strobe, m_skip, m_dir, m_pv, m_init, m_ready = 0;

  always @(posedge clk) begin
    int  dec;
    bit  flip, step;
    if (rst) begin
      foreach (hist[c, k]) hist[c][k] = 0;
      m_filt = 0; m_sector = 0; m_prev = 0; m_pos = 0; m_nstr = 0;
      m_cyc = 0; m_period = 0; m_hv = 0; m_inv = 0; m_strobe = 0;
      m_skip = 0; m_dir = 0; m_pv = 0; m_init = 0; m_ready = 1;
    end else begin
      dec = code2sec(m_filt);
      for (int c = 0; c < 3; c++) begin
        flip = 1;
        for (int k = 0; k < D; k++) if (hist[c][k] == m_filt[c]) flip = 0;
        if (flip) m_filt[c] = ~m_filt[c];
        for (int k = 0; k < D; k++) hist[c][k] = hist[c][k+1];
        hist[c][D] = raw[c];
      end
      m_strobe = 0; m_skip = 0; step = 0;
      if (!enable) begin
        m_init = 0; m_cyc = 0; m_nstr = 0; m_pv = 0;
      end else begin
        if (!m_init) begin
          if (dec != 0) begin m_init = 1; m_prev = dec; end
        end else if (dec != 0 && dec != m_sector) begin
          if (dec == m_prev % 6 + 1)      begin step = 1; m_dir = 1; m_pos++; end
          else if (m_prev == dec % 6 + 1) begin step = 1; m_dir = 0; m_pos--; end
          else m_skip = 1;
          m_prev = dec;
        end
        if (step) begin
          m_strobe = 1; m_period = m_cyc + 1; m_cyc = 0;
          m_pv = (m_nstr >= 1); m_nstr++;
        end else m_cyc++;
      end
      m_sector = dec; m_hv = (dec != 0); m_inv = (dec == 0);
    end
  end

  int strobe_cnt = 0, skip_cnt = 0;

  always @(negedge clk) begin
    if (m_ready) begin
      chk("hall",          longint'({h1, h2, h3}), longint'(m_filt));
      chk("sector",        longint'(sec), m_sector);
      chk("hall_valid",    longint'(hv), longint'(m_hv));
      chk("invalid_error", longint'(inv), longint'(m_inv));
      chk("step_strobe",   longint'(stb), longint'(m_strobe));
      chk("skip_error",    longint'(skp), longint'(m_skip));
      chk("direction",     longint'(dir), longint'(m_dir));
      chk("position",      longint'(pos), longint'(m_pos));
      chk("position8",     longint'(apos), longint'(m_pos));
      chk("period",        longint'(per), m_period);
      chk("period_valid",  longint'(pv), longint'(m_pv));
      chk("stall",         longint'(stl), longint'(m_cyc >= 64'hFF_FFFF));
      if (stb) strobe_cnt++;
      if (skp) skip_cnt++;
    end
  end

  task automatic hold(input bit [2:0] code, input int n);
    raw = code;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int s0, k0;
    rst = 1; enable = 1; raw = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_pos", longint'(pos), 0);
    chk("rst_sector", longint'(sec), 0);
    chk("rst_inv", longint'(inv), 0);
    chk("rst_hall", longint'({h1, h2, h3}), 0);

    // debounce latency: visible after exactly 6 edges
    rst = 0; raw = 3'b100;
    repeat (5) @(posedge clk);
    #1 chk("lat_pre", longint'({h1, h2, h3}), 0);
    @(posedge clk);
    #1 chk("lat_hall", longint'({h1, h2, h3}), 4);
    chk("lat_sector_pre", longint'(sec), 0);
    @(posedge clk);
    #1 chk("lat_sector", longint'(sec), 1);
    chk("init_no_strobe", longint'(stb), 0);
    chk("init_pv", longint'(pv), 0);
    @(negedge clk);
    hold(3'b100, 990);

    // one forward lap
    s0 = strobe_cnt;
    hold(3'b110, 1000); hold(3'b010, 1000); hold(3'b011, 1000);
    hold(3'b001, 1000); hold(3'b101, 1000); hold(3'b100, 1000);
    chk("lap_strobes", strobe_cnt - s0, 6);
    chk("lap_pos", longint'(pos), 6);
    chk("lap_dir", longint'(dir), 1);
    hold(3'b110, 1000);
    chk("fwd7_pos", longint'(pos), 7);
    chk("fwd7_period", longint'(per), 1000);
    chk("fwd7_pv", longint'(pv), 1);

    // reset mid-motion
    raw = 3'b010;
    repeat (3) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 chk("mid_rst_pos", longint'(pos), 0);
    chk("mid_rst_sector", longint'(sec), 0);
    chk("mid_rst_hall", longint'({h1, h2, h3}), 0);
    chk("mid_rst_period", longint'(per), 0);
    chk("mid_rst_pv_dir", longint'({pv, dir, hv, inv, stl}), 0);
    @(negedge clk);
    raw = 3'b100;
    repeat (3) @(negedge clk);
    rst = 0;
    hold(3'b100, 1000);

    // reverse
    hold(3'b101, 1000); hold(3'b001, 1000);
    chk("rev_pos", longint'(pos), -2);
    chk("rev_dir", longint'(dir), 0);
    hold(3'b101, 1000); hold(3'b100, 1000);
    chk("back_pos", longint'(pos), 0);

    // 3-cycle glitch on hall_raw_2
    s0 = strobe_cnt;
    raw = 3'b110;
    repeat (3) begin @(negedge clk); chk("glitch_h2", longint'(h2), 0); end
    raw = 3'b100;
    repeat (20) begin @(negedge clk); chk("glitch_h2", longint'(h2), 0); end
    chk("glitch_strobes", strobe_cnt - s0, 0);
    hold(3'b100, 200);

    // skip 1 -> 3, then legal 3 -> 4
    k0 = skip_cnt;
    hold(3'b010, 1000);
    chk("skip_pulses", skip_cnt - k0, 1);
    chk("skip_pos", longint'(pos), 0);
    hold(3'b011, 1000);
    chk("after_skip_pos", longint'(pos), 1);
    hold(3'b001, 500); hold(3'b101, 500); hold(3'b100, 500);
    chk("to_s1_pos", longint'(pos), 4);

    // invalid code held, then step from remembered sector 1
    hold(3'b111, 500);
    chk("inv_level", longint'(inv), 1);
    chk("inv_sector", longint'(sec), 0);
    chk("inv_hv", longint'(hv), 0);
    hold(3'b110, 500);
    chk("after_inv_pos", longint'(pos), 5);

    // enable low: tracking holds, measurement cleared
    enable = 0;
    hold(3'b110, 50);
    chk("dis_pv", longint'(pv), 0);
    s0 = strobe_cnt;
    hold(3'b010, 500);
    chk("dis_pos", longint'(pos), 5);
    chk("dis_sector", longint'(sec), 3);
    chk("dis_strobes", strobe_cnt - s0, 0);
    enable = 1;
    hold(3'b010, 200);
    chk("reen_pos", longint'(pos), 5);
    hold(3'b011, 300);
    chk("reen_step_pos", longint'(pos), 6);

    // 8-bit period instance: stall after 255 idle cycles
    chk("stall8", longint'(astl), 1);
    chk("stall8_pv", longint'(apv), 0);
    chk("stall24", longint'(stl), 0);
    hold(3'b001, 100);
    chk("stall8_clear", longint'(astl), 0);
    chk("stall8_pv_after", longint'(apv), 0);
    hold(3'b101, 50);
    chk("pv8_second", longint'(apv), 1);
    chk("period8", longint'(aper), 100);
    chk("final_pos", longint'(pos), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
